exposure_timer: RTL
===================

# exposure_timer

Exposure-time register and countdown timer that sits directly upstream of the camera exposure control FSM. It holds the user-selected exposure time and adjusts it with increase/decrease buttons while idle. It counts down that time when the FSM issues `start`, then returns `ovf5` as a single-cycle overflow pulse that ends the FSM's exposure phase.

## Interface
- `W`, 5: width of exposure time and counter.
- `T_MIN`, 2: minimum exposure time in clock cycles (ms); must be ≥ 1.
- `T_MAX`, 30: maximum exposure time; must be < 2^W.
- `T_INIT`, 15: exposure time after reset; T_MIN ≤ T_INIT ≤ T_MAX.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, 1 ms period.
- `reset` in 1: synchronous, active-high reset.
- `exp_increase` in 1: level button input; a rising edge requests +1.
- `exp_decrease` in 1: level button input; a rising edge requests −1.
- `start` in 1: start-exposure request from the control FSM.
- `ovf5` out 1: one-cycle pulse marking the end of exposure.
- `busy` out 1: high while a countdown or overflow is in progress.
- `exposure_time` out W: current exposure setting.

## Operation
- The state register has three states: IDLE, COUNT and OVF.
- **IDLE**
  - A rising edge on exactly one button adjusts `exposure_time` by ±1. The result saturates at T_MAX or T_MIN.
  - Simultaneous rising edges on both buttons produce no change.
  - `start`=1 loads `cnt` ← `exposure_time` and moves to COUNT. When `start` and a button edge occur in the same cycle, `start` wins and the button edge is discarded.
- **COUNT**
  - If `cnt`==1, go to OVF.
  - Otherwise `cnt` ← `cnt`−1.
  - `start` and button edges are ignored.
- **OVF**
  - Lasts one cycle, then returns unconditionally to IDLE.
  - `start` and button edges are ignored.
- **Outputs**
  - `ovf5` = (state==OVF) and `busy` = (state≠IDLE), both decoded from registered state only.
  - `exposure_time` is the register itself.
- **Edge detection**
  - Each button has a registered previous-value flop, updated every cycle in every state.
  - A button held through COUNT/OVF therefore does not fire on return to IDLE.
- **Reset** has priority over everything and is allowed mid-countdown. It sets:
  - state=IDLE, `cnt`=0, `exposure_time`=T_INIT, `ovf5`=0, `busy`=0.
  - Both previous-value flops=1, so a button held across reset does not step.

## Timing
- `start` sampled high at edge t:
  - `busy` is high from t.
  - `ovf5` is high for exactly the one cycle following edge t+E (E = `exposure_time` at t).
  - `busy` falls at edge t+E+1.
- The FSM drops `expose` combinationally on `ovf5`, so the FSM's `expose` is high for exactly E cycles.
- Button latency: an edge seen at edge t updates `exposure_time` at edge t; the new value is visible in the following cycle.
- The next `start` is accepted no earlier than edge t+E+1.
- Counter width W; `cnt` never underflows because the minimum loaded value is T_MIN ≥ 1.
- `exposure_time` changes only in IDLE, so it is constant during any countdown.

## Structure
- Shared package holds:
  - state encoding: IDLE=2'b00, COUNT=2'b01, OVF=2'b10;
  - default T_MIN/T_MAX/T_INIT constants, shared with the FSM's testbench.
- One sub-module, `btn_edge` (previous-value flop plus rising-edge output, synchronous reset to 1), instantiated twice.
- Counter, saturation logic and state register live in `exposure_timer`.

## Test plan
- Reset: after `reset`, `exposure_time`=15, `ovf5`=0, `busy`=0. Hold `exp_increase`=1 through reset release → `exposure_time` stays 15.
- Three separate `exp_increase` pulses → 18. Then 20 more → saturates at 30. Then 30 `exp_decrease` pulses → saturates at 2.
- E=5, `start` at edge t → `ovf5` high only during the cycle after edge t+5, `busy` high edges t..t+5. Repeat with E=2 and E=30.
- Button pulses and a second `start` during COUNT → `exposure_time` unchanged, `ovf5` timing unchanged. Simultaneous inc+dec in IDLE → no change.
- `start` coinciding with an `exp_increase` edge at E=10 → countdown uses 10, `exposure_time` stays 10.
- `reset` asserted at edge t+3 of a 10-cycle count → `ovf5` never pulses, `busy`=0, `exposure_time`=15.

Source files
------------

// File: rtl/exposure_timer_pkg.sv
// Shared constants and state encoding for the exposure countdown timer and its
// upstream control FSM environment.
package exposure_timer_pkg;
  localparam int W_DEF      = 5;
  localparam int T_MIN_DEF  = 2;
  localparam int T_MAX_DEF  = 30;
  localparam int T_INIT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_OVF   = 2'b10
  } state_t;
endpackage

// File: rtl/exposure_timer_if.sv
// Control-side bundle between the exposure FSM (master) and the timer (slave).
interface exposure_timer_if
  import exposure_timer_pkg::*;
#(
  parameter int W = W_DEF
);
  logic         exp_increase;
  logic         exp_decrease;
  logic         start;
  logic         ovf5;
  logic         busy;
  logic [W-1:0] exposure_time;

  modport master (
    output exp_increase, exp_decrease, start,
    input  ovf5, busy, exposure_time
  );

  modport slave (
    input  exp_increase, exp_decrease, start,
    output ovf5, busy, exposure_time
  );
endinterface

// File: rtl/exposure_timer_btn_edge.sv
// Button rising-edge detector; previous value resets high so a button held
// across reset does not produce a spurious edge.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  logic prev_q, prev_d;

  always_comb prev_d = btn;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= prev_d;
  end

  assign rise = btn & ~prev_q;
endmodule

// File: rtl/exposure_timer.sv
// Exposure-time register with saturating +/- adjust and a down-counter that
// emits a one-cycle ovf5 pulse after exposure_time cycles.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; button edges adjust exposure_time
// ST_COUNT | counting cnt down; terminal count 1 moves to ST_OVF
// ST_OVF   | single-cycle end-of-exposure pulse, then back to ST_IDLE
module exposure_timer
  import exposure_timer_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int T_MIN  = T_MIN_DEF,
  parameter int T_MAX  = T_MAX_DEF,
  parameter int T_INIT = T_INIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  exposure_timer_if.slave  tif
);
  localparam logic [W-1:0] TMIN_W  = W'(T_MIN);
  localparam logic [W-1:0] TMAX_W  = W'(T_MAX);
  localparam logic [W-1:0] TINIT_W = W'(T_INIT);
  localparam logic [W-1:0] ONE_W   = W'(1);

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] exp_q, exp_d;
  logic         inc_rise, dec_rise;

  btn_edge u_inc_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (tif.exp_increase),
    .rise  (inc_rise)
  );

  btn_edge u_dec_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (tif.exp_decrease),
    .rise  (dec_rise)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    unique case (state_q)
      ST_IDLE: begin
        // start takes priority; a coincident button edge is dropped
        if (tif.start) begin
          cnt_d   = exp_q;
          state_d = ST_COUNT;
        end else if (inc_rise && !dec_rise) begin
          if (exp_q < TMAX_W) exp_d = exp_q + ONE_W;
        end else if (dec_rise && !inc_rise) begin
          if (exp_q > TMIN_W) exp_d = exp_q - ONE_W;
        end
      end
      ST_COUNT: begin
        if (cnt_q == ONE_W) state_d = ST_OVF;
        else                cnt_d   = cnt_q - ONE_W;
      end
      ST_OVF:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      exp_q   <= TINIT_W;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
    end
  end

  assign tif.ovf5          = (state_q == ST_OVF);
  assign tif.busy          = (state_q != ST_IDLE);
  assign tif.exposure_time = exp_q;
endmodule
